// File: rtl/bounce_mon_pkg.sv
// Shared types and constants for the bounce counter monitor.
//   mon_state_e : tracking FSM states
//   SEG_BLANK   : all segments off (active-low)
//   SEG_TABLE   : active-low a..g patterns for digits 0..9, seg[6]=a
//   bcd_inc     : two-digit BCD increment, 99 wraps to 00
package bounce_mon_pkg;

    typedef enum logic [1:0] {
        MON_INIT,
        MON_SYNC,
        MON_UP,
        MON_DOWN
    } mon_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost element of the concatenation.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern.
//   bcd_i : 4-bit digit code
//   seg_o : active-low segments a..g (seg_o[6]=a); codes above 9 blank
module seg7_decoder
    import bounce_mon_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_TABLE[bcd_i];
        end
    end

endmodule

// File: rtl/bounce_count_monitor.sv
// Monitors an up/down bouncing counter: tracks direction, pulses on peak
// and valley, counts round trips in BCD, flags illegal steps and scans the
// count onto a two-digit active-low seven-segment display.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   sample_en  : cont_in valid this cycle
//   cont_in    : upstream counter value
//   err_clr    : synchronous clear of step_err (a new error wins)
//   dir_out    : 0 = counting up, 1 = counting down
//   peak       : one-cycle pulse when MAXV is sampled
//   valley     : one-cycle pulse when 0 is reached on the way down
//   step_err   : sticky illegal-step flag
//   cycles_bcd : round trips mod 100, [7:4] tens, [3:0] ones
//   seg, an    : active-low segments and digit enables (an[0] = ones)
module bounce_count_monitor
    import bounce_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] cont_in,
    input  logic             err_clr,
    output logic             dir_out,
    output logic             peak,
    output logic             valley,
    output logic             step_err,
    output logic [7:0]       cycles_bcd,
    output logic [6:0]       seg,
    output logic [1:0]       an
);

    localparam logic [WIDTH-1:0] MAXV  = '1;
    localparam int unsigned      CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(SCAN_DIV - 1);

    mon_state_e       state_q;
    logic [WIDTH-1:0] prev_q;
    logic             dir_q, peak_q, valley_q, err_q;
    logic [7:0]       bcd_q;
    logic [CNT_W-1:0] scan_q;
    logic             sel_q;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;

    logic             up_ok, down_ok, go_up, go_down;
    logic [3:0]       digit;
    logic [6:0]       seg_dec;

    // Steps never wrap: 15->0 and 0->15 are illegal.
    assign up_ok   = ({1'b0, cont_in} == ({1'b0, prev_q} + 1'b1));
    assign down_ok = (prev_q != '0) && (cont_in == (prev_q - 1'b1));
    // SYNC accepts either direction; UP/DOWN only their own.
    assign go_up   = up_ok && ((state_q == MON_SYNC) || (state_q == MON_UP));
    assign go_down = down_ok && ((state_q == MON_SYNC) || (state_q == MON_DOWN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MON_INIT;
            prev_q   <= '0;
            dir_q    <= 1'b0;
            peak_q   <= 1'b0;
            valley_q <= 1'b0;
            err_q    <= 1'b0;
            bcd_q    <= 8'h00;
        end else begin
            peak_q   <= 1'b0;
            valley_q <= 1'b0;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (sample_en) begin
                prev_q <= cont_in;
                if (state_q == MON_INIT) begin
                    state_q <= MON_SYNC;
                end else if (go_up) begin
                    if (cont_in == MAXV) begin
                        peak_q  <= 1'b1;
                        dir_q   <= 1'b1;
                        state_q <= MON_DOWN;
                    end else begin
                        dir_q   <= 1'b0;
                        state_q <= MON_UP;
                    end
                end else if (go_down) begin
                    if (cont_in == '0) begin
                        valley_q <= 1'b1;
                        dir_q    <= 1'b0;
                        bcd_q    <= bcd_inc(bcd_q);
                        state_q  <= MON_UP;
                    end else begin
                        dir_q   <= 1'b1;
                        state_q <= MON_DOWN;
                    end
                end else begin
                    // Set after the clear so a coincident error wins.
                    err_q   <= 1'b1;
                    state_q <= MON_SYNC;
                end
            end
        end
    end

    assign digit = sel_q ? bcd_q[7:4] : bcd_q[3:0];

    seg7_decoder u_seg7_decoder (
        .bcd_i (digit),
        .seg_o (seg_dec)
    );

    // seg and an both derive from sel_q in the same edge, keeping them aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q <= '0;
            sel_q  <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= 2'b11;
        end else begin
            if (scan_q == TERM) begin
                scan_q <= '0;
                sel_q  <= ~sel_q;
            end else begin
                scan_q <= scan_q + 1'b1;
            end
            seg_q <= seg_dec;
            an_q  <= sel_q ? 2'b01 : 2'b10;
        end
    end

    assign dir_out    = dir_q;
    assign peak       = peak_q;
    assign valley     = valley_q;
    assign step_err   = err_q;
    assign cycles_bcd = bcd_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: doc/bounce_count_monitor.md
Name: bounce_count_monitor

Overview:
- Downstream consumer of the up/down bouncing counter. The counter runs 0→MAXV, then back down to 0, and repeats.
- Samples the counter value and tracks its direction.
- Flags peak and valley turnarounds and counts complete round trips in two-digit BCD.
- Detects illegal steps and drives a multiplexed two-digit active-low seven-segment display of the round-trip count.

Parameters:
WIDTH, 4, width of sampled counter value; MAXV = 2**WIDTH-1 (localparam)
SCAN_DIV, 16, clock cycles each display digit stays enabled (>=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
sample_en  input  1  cont_in is valid this cycle; tie high for a free-running counter
cont_in  input  WIDTH  counter value from the upstream counter
err_clr  input  1  synchronous clear of step_err
dir_out  output  1  tracked direction: 0 = up, 1 = down
peak  output  1  one-cycle pulse: counter reached MAXV
valley  output  1  one-cycle pulse: counter returned to 0
step_err  output  1  sticky illegal-step flag
cycles_bcd  output  8  round trips mod 100; [7:4] tens, [3:0] ones
seg  output  7  active-low segments, seg[6]=a … seg[0]=g
an  output  2  active-low digit enables; an[0] ones, an[1] tens

Behaviour:
- Reset low, immediate (no clock edge needed):
  - dir_out=0, peak=0, valley=0, step_err=0, cycles_bcd=8'h00.
  - seg=7'h7F, an=2'b11.
  - State INIT, prev=0, scan count 0, digit select 0.
- All outputs registered. peak, valley, dir_out and cycles_bcd update on the edge that samples the qualifying cont_in, so they are visible the following cycle.
- sample_en=0: tracking state, prev, dir and counts all hold. peak/valley are 0. The display scan keeps running.
- Tracking FSM, acting only when sample_en=1:
  - INIT: prev←cont_in → SYNC.
  - SYNC:
    - cont_in==prev+1 → UP, dir_out=0.
    - cont_in==prev-1 → DOWN, dir_out=1.
    - otherwise → step_err=1, stay SYNC.
    - prev←cont_in in all cases.
    - Entering UP at MAXV or DOWN at 0 applies the extreme rules below.
  - UP: expects cont_in==prev+1 (no wrap).
    - If cont_in==MAXV → peak=1, dir_out=1, next state DOWN.
  - DOWN: expects cont_in==prev-1.
    - If cont_in==0 → valley=1, dir_out=0, next state UP, cycles_bcd increments.
  - Mismatch in UP/DOWN → step_err=1, prev←cont_in, next state SYNC. dir_out holds; no pulse; no count.
- Repeated sample (cont_in==prev) is a mismatch.
- BCD increment: ones 9→0 carries into tens; 99→00 wraps silently.
- step_err is cleared only by reset or err_clr. If err_clr and a new error occur in the same cycle, set wins.
- dir_out holds its value in INIT and SYNC.
- Display scan:
  - Counter 0..SCAN_DIV-1. At the terminal count it returns to 0 and toggles the digit select.
  - Select 0: an=2'b10, seg shows the ones digit. Select 1: an=2'b01, seg shows the tens digit.
  - seg and an are registered together so they are always aligned. The first digit appears one cycle after reset release.
- Decoder (active-low, a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other code = 1111111.
- Reset mid-operation: on release, tracking restarts in INIT and step_err is not raised spuriously.

Decomposition:
- Package bounce_mon_pkg holds:
  - typedef enum logic [1:0] {MON_INIT, MON_SYNC, MON_UP, MON_DOWN}.
  - Constants SEG_BLANK = 7'h7F and the seven-segment pattern table.
- One combinational sub-module, seg7_decoder (4-bit BCD in, 7-bit active-low out), instantiated once after the digit mux.

Test Plan:
1. Hold reset low 3 cycles → seg=7F, an=11, all other outputs 0. Release, then drive 0,1..15,14..0 with sample_en=1:
   - dir_out=1 and peak pulses 1 cycle after cont_in=15.
   - valley pulses 1 cycle after the return to 0.
   - cycles_bcd=8'h01, step_err=0 throughout.
2. Drive 100 full round trips → cycles_bcd reads 09→10 at the tenth valley, reaches 99, then wraps to 00.
3. In UP, jump 5→9 → step_err=1 next cycle, no pulse.
   - Then 10,11 resync to UP with no further change.
   - err_clr pulse → step_err=0.
   - err_clr coincident with a new bad step → step_err stays 1.
4. sample_en=0 for 10 cycles while cont_in changes randomly → state, dir_out, cycles_bcd and step_err unchanged, no pulses.
5. SCAN_DIV=4, cycles_bcd=8'h42 → an alternates 10/01 every 4 cycles.
   - seg=0010010 while an=10.
   - seg=1001100 while an=01.
6. Assert reset asynchronously mid-descent at cont_in=7 → outputs clear without a clock edge. After release, samples 7,6,5 → dir_out=1 after 6, step_err stays 0.
